dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: services the load/store requests the MEM stage issues
//  (MemRead_2DM/MemWrite_2DM, data_address_2DM, data_write_2DM).
//  Multi-cycle word-organised RAM with big-endian byte-lane stores.
//  Raises mem_stall to freeze the pipeline while a request is in flight.
//  Returns the full aligned word on data_read_fDM; MEM does sub-word extract/extend.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH words (byte range 4*depth)
//  LATENCY     2   wait cycles before the array access; legal 1..15
// PORTS
//  CLK               in   1   clock, rising edge
//  RESET             in   1   asynchronous, active-high reset
//  MemRead_2DM       in   1   load request, held by requester while mem_stall=1
//  MemWrite_2DM      in   1   store request, held by requester while mem_stall=1
//  data_address_2DM  in   32  byte address
//  data_write_2DM    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  store_size        in   2   00 byte, 01 half, 10 word, 11 treated as word
//  data_read_fDM     out  32  registered read word
//  mem_stall         out  1   pipeline freeze
//  mem_done          out  1   one-cycle completion pulse
//  mem_err           out  1   one-cycle error pulse, coincident with mem_done
// BEHAVIOUR
//  Reset: state=IDLE, data_read_fDM=0, mem_done=0, mem_err=0, mem_stall=0, counter=0.
//   Array contents are not cleared. Power-up contents are undefined.
//  Reset mid-request: abort to IDLE. No array write occurs unless the access edge
//   has already passed.
//  FSM IDLE/WAIT/RESP:
//   IDLE: req = MemRead_2DM|MemWrite_2DM.
//    If req: capture addr/wdata/size/op, cnt<=LATENCY-1, go WAIT.
//    mem_stall = req (combinational, same cycle).
//   WAIT: mem_stall=1.
//    cnt!=0: decrement.
//    cnt==0: perform the array access on this edge, go RESP.
//   RESP: mem_stall=0, mem_done=1, mem_err per checks; always go IDLE.
//    Request inputs are ignored in RESP (still the old request), so it cannot
//    retrigger. A new request is sampled only in IDLE.
//  Latency: request first seen at cycle 0 -> mem_stall high cycles 0..LATENCY,
//   RESP at cycle LATENCY+1. Back-to-back requests cost LATENCY+2 cycles each.
//  Reads: data_read_fDM <= mem[addr[ADDR_WIDTH+1:2]] at the access edge.
//   Valid from RESP; held until the next read completes.
//   Misalignment is not checked on reads.
//  Stores (big-endian lanes, off = addr[1:0]):
//   byte: off0->[31:24], off1->[23:16], off2->[15:8], off3->[7:0].
//   half: off0->[31:16], off2->[15:0]; off1/off3 = misaligned.
//   word: off0 only; any other offset = misaligned.
//   Unwritten lanes are preserved (byte-enable write).
//  Errors: misaligned store or addr[31:ADDR_WIDTH+2]!=0.
//   Array write suppressed; a read returns 0; mem_err=1 in RESP.
//  Read+write both asserted: treated as a write; data_read_fDM unchanged.
// TESTING
//  Reset: assert RESET mid-WAIT -> all outputs 0 immediately, FSM in IDLE,
//   target word unchanged.
//  Word RT, LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 ->
//   stall 3 cycles, done in cycle 3, data_read_fDM=0xDEADBEEF.
//  Byte lanes: SW 0 @0x20; SB 0xAA @0x21; SH 0x1234 @0x22 ->
//   LW @0x20 returns 0x00AA1234.
//  Misaligned: SW @0x24 preloaded 0x11111111, then SH 0xFFFF @0x25 ->
//   mem_err=1 with mem_done, word stays 0x11111111.
//  Range: LW @(4<<ADDR_WIDTH) -> mem_err=1, data_read_fDM=0.
//  Held request: keep MemRead high through RESP -> exactly one access,
//   one done pulse, re-arm only in the following IDLE cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// A single request is captured in IDLE and held in WAIT for LATENCY cycles.
// The array access happens on the last WAIT edge. RESP then reports completion
// with a one-cycle mem_done (plus mem_err when the access was rejected).
// Storage is word-organised. Stores use big-endian byte lanes with byte enables.
// Loads always return the full aligned word, and MEM does the sub-word extract.

module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  store_size,
    output logic [31:0] data_read_fDM,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter is loaded with LATENCY-1 so that WAIT lasts exactly LATENCY cycles.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        write_q;

    logic [31:0] mem [0:DEPTH-1];

    logic                  req;
    logic                  access;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic                  range_err;
    logic                  misaligned;
    logic                  access_err;
    logic [3:0]            byte_en;
    logic [31:0]           lane_data;

    assign req      = MemRead_2DM | MemWrite_2DM;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign byte_off = addr_q[1:0];

    // Any bit set above the array's byte range is an out-of-range request.
    assign range_err = |addr_q[31:ADDR_WIDTH+2];

    // Decode the store size into lane enables and lane-replicated data.
    // byte_en[3] is lane [31:24]. It is the lowest byte address because the array is big-endian.
    always_comb begin
        byte_en    = 4'b0000;
        lane_data  = wdata_q;
        misaligned = 1'b0;
        case (size_q)
            SIZE_BYTE: begin
                byte_en   = 4'b1000 >> byte_off;
                lane_data = {4{wdata_q[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = byte_off[1] ? 4'b0011 : 4'b1100;
                lane_data  = {2{wdata_q[15:0]}};
                misaligned = byte_off[0];
            end
            default: begin
                byte_en    = 4'b1111;
                lane_data  = wdata_q;
                misaligned = (byte_off != 2'b00);
            end
        endcase
    end

    // Loads only check the range. Stores also reject misaligned halfwords and words.
    assign access_err = range_err | (write_q & misaligned);

    // The pipeline freezes as soon as a request shows up in IDLE and stays frozen through WAIT.
    // The outputs must all read 0 while RESET is high, even if the requester still drives a request.
    assign mem_stall = ~RESET & (((state == IDLE) & req) | (state == WAIT));

    // The array is written only on the access edge, one byte lane at a time. It has no reset.
    always_ff @(posedge CLK) begin
        if (access && write_q && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Request FSM: IDLE captures, WAIT counts down and accesses, RESP pulses done/err.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            size_q        <= 2'b00;
            write_q       <= 1'b0;
            data_read_fDM <= 32'd0;
            mem_done      <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= data_address_2DM;
                        wdata_q <= data_write_2DM;
                        size_q  <= store_size;
                        write_q <= MemWrite_2DM;
                        cnt     <= CNT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!write_q) begin
                            data_read_fDM <= range_err ? 32'd0 : mem[word_idx];
                        end
                        mem_done <= 1'b1;
                        mem_err  <= access_err;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
